// File: rtl/de2_sopc_pio_pkg.sv
// de2_sopc_pio_pkg
// Shared definitions for the DE2 SOPC PIO slaves (key input PIO now, LED and
// other PIO variants later): Avalon register word offsets and the edge-capture
// sensitivity selector.
package de2_sopc_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        RISING  = 2'd0,
        FALLING = 2'd1,
        ANY     = 2'd2
    } edge_type_e;

endpackage

// File: rtl/de2_sopc_sync_bus.sv
// de2_sopc_sync_bus
// WIDTH-wide multi-flop synchronizer for asynchronous inputs.
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-high reset, clears every stage to 0
//   d     - asynchronous input bus
//   q     - synchronized output (last stage)
module de2_sopc_sync_bus #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/de2_sopc_key_pio.sv
// de2_sopc_key_pio
// Avalon-MM input PIO for the DE2 push buttons: synchronized level readback,
// per-bit edge capture (write-1-to-clear) and a maskable interrupt.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   address     - word address (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE)
//   chipselect, write_n, writedata - Avalon write strobe and data
//   in_port     - asynchronous external inputs
//   readdata    - registered read data, one cycle latency
//   irq         - |(EDGECAPTURE & IRQMASK)
module de2_sopc_key_pio
    import de2_sopc_pio_pkg::*;
#(
    parameter int         WIDTH       = 4,
    parameter edge_type_e EDGE_TYPE   = FALLING,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Edges stay suppressed until prev holds a genuinely synchronized sample.
    localparam int WARM = SYNC_STAGES + 1;
    localparam int CW   = $clog2(WARM + 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] clr_bits;
    logic [CW-1:0]    warm_cnt;
    logic             warm_done;
    logic             wr;

    de2_sopc_sync_bus #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (sync)
    );

    assign warm_done = (warm_cnt == CW'(WARM));
    assign wr        = chipselect & ~write_n;
    assign clr_bits  = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            RISING:  edge_raw = sync & ~prev;
            FALLING: edge_raw = ~sync & prev;
            default: edge_raw = sync ^ prev;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            warm_cnt <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            prev <= sync;
            if (!warm_done)
                warm_cnt <= warm_cnt + 1'b1;
            if (wr && address == ADDR_IRQMASK)
                irq_mask <= writedata[WIDTH-1:0];
            // A new edge wins over a simultaneous clear of the same bit.
            edge_cap <= (edge_cap & ~clr_bits) | (warm_done ? edge_raw : '0);
            case (address)
                ADDR_DATA:    readdata <= 32'(sync);
                ADDR_IRQMASK: readdata <= 32'(irq_mask);
                ADDR_EDGECAP: readdata <= 32'(edge_cap);
                default:      readdata <= '0;
            endcase
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: doc/de2_sopc_key_pio.md
# de2_sopc_key_pio

Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO on the DE2 SOPC system bus. It synchronizes the DE2 push-button inputs, exposes their level, latches per-bit edge events, and raises a maskable interrupt to the Nios II. It sits under the SOPC interconnect beside the LED PIO and shares its register-window style (2-bit word address, 32-bit data).

## Interface
Parameters:
- WIDTH, 4, number of input bits (DE2 KEY[3:0])
- EDGE_TYPE, FALLING, edge that sets edgecapture: RISING, FALLING or ANY
- SYNC_STAGES, 2, synchronizer flop depth (≥2)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  word address of register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data
- irq  out  1  interrupt request, active-high

## Operation
- Register map:
  - 0 DATA (RO): synchronized in_port. Writes are ignored.
  - 1: reserved. Reads 0; writes ignored.
  - 2 IRQMASK (RW): WIDTH bits.
  - 3 EDGECAPTURE (RW1C): writing 1 to a bit clears that bit; 0 leaves it.
- Upper 32-WIDTH readdata bits are always 0.
- A write occurs when chipselect=1 and write_n=0.
- Each in_port bit passes through SYNC_STAGES flops, giving `sync`. A further flop holds `prev`.
- Edge detect (per bit):
  - RISING: sync & ~prev
  - FALLING: ~sync & prev
  - ANY: sync ^ prev
- A detected edge sets the corresponding EDGECAPTURE bit. The bit stays set until cleared by software.
- Simultaneous clear write and new edge on the same bit: the set wins, and the bit stays 1.
- irq = |(EDGECAPTURE & IRQMASK), combinational from registers, with no extra delay.
- Warm-up: after reset deasserts, a small counter suppresses edge detection for SYNC_STAGES+1 cycles. This prevents a spurious edge from the reset value of 0 versus the real input level. DATA reads are valid during warm-up.

## Timing
- Reset values: sync, prev, IRQMASK, EDGECAPTURE = 0; readdata = 0; irq = 0; warm-up counter = 0.
- Reset asserted mid-operation clears all state immediately, including pending captures, and restarts warm-up.
- Read latency is 1 cycle. readdata is registered every cycle from the current address, independent of chipselect and write_n.
- A write to IRQMASK affects irq in the cycle after the write edge.
- A write to EDGECAPTURE deasserts irq in the cycle after the write edge, if no other masked bit remains set.
- Input path (SYNC_STAGES=2), with in_port changed and stable before clock edge k:
  - sync reflects it after edge k+1.
  - DATA readable (readdata) after edge k+2 when address=0 is presented after edge k+1.
  - EDGECAPTURE bit and irq set after edge k+2.
- Glitches shorter than one clk period may be missed. No debounce is applied; software debounces.

## Structure
- Package de2_sopc_pio_pkg:
  - register offset constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3)
  - EDGE_TYPE enumeration (RISING, FALLING, ANY)
- The future LED/PIO variants reuse this package.
- Sub-module de2_sopc_sync_bus: WIDTH-wide, SYNC_STAGES-deep synchronizer with async active-high reset.
- The top level holds edge detect, warm-up counter, registers, read mux and irq.

## Test plan
- Reset release with in_port=4'b1111, EDGE_TYPE=FALLING: after 10 cycles, EDGECAPTURE reads 0, DATA reads 0xF, irq=0.
- IRQMASK=0x1; drive in_port[0] 1→0 at edge k: EDGECAPTURE=0x1 and irq=1 after edge k+2; DATA reads 0xE.
- Write 0x1 to address 3: irq falls the next cycle, EDGECAPTURE reads 0. Write 0x0 to address 3: no change.
- Clear write to bit 2 in the same cycle as a new falling edge on bit 2: EDGECAPTURE bit 2 remains 1.
- IRQMASK=0x0 with EDGECAPTURE=0x6: irq=0. Write IRQMASK=0x4: irq=1 the next cycle. Reads of address 1 return 0, and writes to addresses 0 and 1 change nothing.
- Assert reset while EDGECAPTURE=0xF and IRQMASK=0xF: irq and readdata go to 0 without waiting for a clock edge.
